// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FLUSH
   } fetch_state_t;

   localparam int INSTR_BYTES = 4;
   localparam int XLEN        = 32;

   // Decode-facing entry for the default 32-bit core.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with push/pop/flush. DEPTH must be a power of 2 (pointers wrap naturally).
// Push while full is accepted only together with a pop. Flush wins over push and pop.
module riscv_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_en, pop_en;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];
   assign push_en = push_i && (!full_o || pop_i) && !flush_i;
   assign pop_en  = pop_i && !empty_o && !flush_i;

   // Next pointers and occupancy.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_en) wptr_d = wptr_q + AW'(1);
         if (pop_en)  rptr_d = rptr_q + AW'(1);
         count_d = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
      end
   end

   // Pointer/count registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: credit-limited req/gnt/rvalid fetcher feeding a prefetch FIFO,
// with redirect/flush of in-flight fetches. Optional macro RISCV_FETCH_PERF_EN adds
// fetch_count_o, a count of instructions handed to decode.
module riscv_fetch_unit
   import riscv_pkg::*;
#(
   parameter int                   WORD_SIZE  = 32,
   parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
   parameter int                   FIFO_DEPTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic                 imem_req_o,
   output logic [WORD_SIZE-1:0] imem_addr_o,
   input  logic                 imem_gnt_i,
   input  logic                 imem_rvalid_i,
   input  logic [WORD_SIZE-1:0] imem_rdata_i,
   input  logic                 redirect_i,
   input  logic [WORD_SIZE-1:0] redirect_pc_i,
   output logic                 instr_valid_o,
   output logic [WORD_SIZE-1:0] instr_o,
   output logic [WORD_SIZE-1:0] instr_pc_o,
   input  logic                 instr_ready_i
`ifdef RISCV_FETCH_PERF_EN
   ,
   output logic [31:0]          fetch_count_o
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [WORD_SIZE-1:0] instr;
      logic [WORD_SIZE-1:0] pc;
   } entry_t;

   fetch_state_t         state_q, state_d;
   logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]        outstanding_q, outstanding_d;
   logic [CW-1:0]        drop_cnt_q, drop_cnt_d;

   logic                 flush, pcq_push, pcq_pop, fifo_push, instr_pop;
   logic                 gnt_ok, rv_ok;
   logic [WORD_SIZE-1:0] pcq_head;
   logic [CW-1:0]        pcq_count, fifo_count;
   logic                 pcq_full, pcq_empty, fifo_full, fifo_empty;
   entry_t               fifo_in, fifo_head;

   // Credit: never have more requests in flight plus buffered than the FIFO can hold.
   assign imem_req_o  = (state_q == RUN) && ((outstanding_q + fifo_count) < CW'(FIFO_DEPTH));
   assign imem_addr_o = fetch_pc_q;
   assign gnt_ok      = imem_req_o && imem_gnt_i;
   assign rv_ok       = imem_rvalid_i && (outstanding_q != '0);

   assign instr_valid_o = !fifo_empty;
   assign instr_o       = instr_valid_o ? fifo_head.instr : '0;
   assign instr_pc_o    = instr_valid_o ? fifo_head.pc : '0;
   assign instr_pop     = instr_valid_o && instr_ready_i;
   assign fifo_in       = '{instr: imem_rdata_i, pc: pcq_head};

   // Next state, fetch PC and in-flight bookkeeping; redirect overrides everything.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      drop_cnt_d    = drop_cnt_q;
      outstanding_d = outstanding_q + CW'(gnt_ok) - CW'(rv_ok);
      flush         = 1'b0;
      pcq_push      = 1'b0;
      pcq_pop       = 1'b0;
      fifo_push     = 1'b0;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (gnt_ok) begin
               pcq_push   = 1'b1;
               fetch_pc_d = fetch_pc_q + WORD_SIZE'(INSTR_BYTES);
            end
            if (rv_ok) begin
               pcq_pop   = 1'b1;
               fifo_push = 1'b1;
            end
         end
         FLUSH: begin
            if (rv_ok) drop_cnt_d = drop_cnt_q - CW'(1);
            if (drop_cnt_d == '0) state_d = RUN;
         end
         default: state_d = BOOT;
      endcase
      if (redirect_i) begin
         // Everything still in flight after this edge belongs to the old path.
         flush      = 1'b1;
         fetch_pc_d = {redirect_pc_i[WORD_SIZE-1:2], 2'b00};
         drop_cnt_d = outstanding_d;
         state_d    = (outstanding_d != '0) ? FLUSH : RUN;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   // Addresses of granted, not-yet-returned requests, in issue order.
   riscv_sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_pc_queue (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush),
      .push_i  (pcq_push),
      .data_i  (fetch_pc_q),
      .pop_i   (pcq_pop),
      .data_o  (pcq_head),
      .full_o  (pcq_full),
      .empty_o (pcq_empty),
      .count_o (pcq_count)
   );

   // Prefetch buffer presented to decode.
   riscv_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_prefetch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush),
      .push_i  (fifo_push),
      .data_i  (fifo_in),
      .pop_i   (instr_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifdef RISCV_FETCH_PERF_EN
   logic [31:0] fetch_count_q, fetch_count_d;

   // Delivered-instruction counter; survives redirects.
   always_comb fetch_count_d = fetch_count_q + 32'(instr_pop);

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) fetch_count_q <= '0;
      else       fetch_count_q <= fetch_count_d;
   end

   assign fetch_count_o = fetch_count_q;
`endif

   // Responses with nothing outstanding are ignored by the logic above.
   a_rvalid_unexpected: assert property (@(posedge clk_i) disable iff (rst_i)
      !(imem_rvalid_i && outstanding_q == '0));
   a_pcq_tracks: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == RUN) |-> (pcq_count == outstanding_q));
   a_pcq_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(pcq_push && pcq_full && !flush));
   a_pcq_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
      !(pcq_pop && pcq_empty));
   a_fifo_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(fifo_push && fifo_full && !instr_pop && !flush));

endmodule
